// File: rtl/text_reveal_ctrl.sv
// Typewriter-style text line renderer: a character buffer, a two-stage pixel
// pipeline that drives an external 16x16 glyph ROM, and a frame-paced reveal FSM.
module text_reveal_ctrl #(
  parameter int          TEXT_LEN      = 16,
  parameter int          ORIGIN_X      = 0,
  parameter int          ORIGIN_Y      = 0,
  parameter int          REVEAL_FRAMES = 8,
  parameter logic [15:0] FG_COLOR      = 16'hFFFF,
  parameter logic [15:0] BG_COLOR      = 16'h0000,
  localparam int         AW            = $clog2(TEXT_LEN)
) (
  input  logic          vga_clk,
  input  logic          sys_rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [4:0]    wr_char,
  input  logic          start,
  input  logic          clear,
  input  logic          frame_start,
  input  logic          pix_valid,
  input  logic [9:0]    pix_x,
  input  logic [9:0]    pix_y,
  output logic [4:0]    letter_i,
  output logic [3:0]    letter_x,
  output logic [3:0]    letter_y,
  input  logic          letter_o,
  output logic [15:0]   pix_data,
  output logic          pix_data_valid,
  output logic          busy,
  output logic          done
);

  localparam int FW = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
  localparam int RW = AW + 1;
  localparam logic [FW-1:0] FRAME_LAST  = FW'(REVEAL_FRAMES - 1);
  localparam logic [RW-1:0] REVEAL_LAST = RW'(TEXT_LEN - 1);
  localparam logic [RW-1:0] REVEAL_FULL = RW'(TEXT_LEN);
  localparam logic [10:0]   OX          = 11'(ORIGIN_X);
  localparam logic [10:0]   OY          = 11'(ORIGIN_Y);
  localparam logic [10:0]   BOX_W       = 11'(16 * TEXT_LEN);
  localparam logic [10:0]   BOX_H       = 11'd16;
  localparam logic [4:0]    SPACE       = 5'd26;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REVEAL,
    ST_SHOW
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] reveal_cnt_q, reveal_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          done_q, done_d;

  logic [4:0]    char_q [TEXT_LEN];
  logic [4:0]    char_d [TEXT_LEN];

  logic          in_box_q, in_box_d;
  logic [AW-1:0] slot_q, slot_d;
  logic [3:0]    lx_q, lx_d;
  logic [3:0]    ly_q, ly_d;
  logic          valid1_q, valid1_d;
  logic [15:0]   pix_data_q, pix_data_d;
  logic          valid2_q, valid2_d;

  logic [10:0]   dx, dy;
  logic [4:0]    code;
  logic          slot_vis;

  // Reveal sequencing; clear beats start, and start beats any frame tick.
  always_comb begin
    state_d      = state_q;
    reveal_cnt_d = reveal_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    done_d       = 1'b0;
    if (clear) begin
      state_d      = ST_IDLE;
      reveal_cnt_d = '0;
      frame_cnt_d  = '0;
    end else if (start) begin
      state_d      = ST_REVEAL;
      reveal_cnt_d = '0;
      frame_cnt_d  = '0;
    end else if (state_q == ST_REVEAL && frame_start) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        if (reveal_cnt_q == REVEAL_LAST) begin
          reveal_cnt_d = REVEAL_FULL;
          state_d      = ST_SHOW;
          done_d       = 1'b1;
        end else begin
          reveal_cnt_d = reveal_cnt_q + 1'b1;
        end
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    char_d = char_q;
    if (wr_en) char_d[wr_addr] = wr_char;
  end

  // 11-bit subtraction keeps coordinates left of/above the origin out of the box.
  always_comb begin
    dx       = {1'b0, pix_x} - OX;
    dy       = {1'b0, pix_y} - OY;
    in_box_d = pix_valid && ({1'b0, pix_x} >= OX) && (dx < BOX_W)
               && ({1'b0, pix_y} >= OY) && (dy < BOX_H);
    slot_d   = dx[AW+3:4];
    lx_d     = dx[3:0];
    ly_d     = dy[3:0];
    valid1_d = pix_valid;
  end

  always_comb begin
    code     = char_q[slot_q];
    slot_vis = (state_q == ST_SHOW)
               || (state_q == ST_REVEAL && {1'b0, slot_q} < reveal_cnt_q);
    letter_i = (in_box_q && slot_vis && code <= SPACE) ? code : SPACE;
    letter_x = in_box_q ? lx_q : 4'd0;
    letter_y = in_box_q ? ly_q : 4'd0;
    pix_data_d = (in_box_q && letter_o) ? FG_COLOR : BG_COLOR;
    valid2_d   = valid1_q;
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      reveal_cnt_q <= '0;
      frame_cnt_q  <= '0;
      done_q       <= 1'b0;
      for (int i = 0; i < TEXT_LEN; i++) char_q[i] <= SPACE;
      in_box_q     <= 1'b0;
      slot_q       <= '0;
      lx_q         <= '0;
      ly_q         <= '0;
      valid1_q     <= 1'b0;
      pix_data_q   <= BG_COLOR;
      valid2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      reveal_cnt_q <= reveal_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      done_q       <= done_d;
      char_q       <= char_d;
      in_box_q     <= in_box_d;
      slot_q       <= slot_d;
      lx_q         <= lx_d;
      ly_q         <= ly_d;
      valid1_q     <= valid1_d;
      pix_data_q   <= pix_data_d;
      valid2_q     <= valid2_d;
    end
  end

  assign pix_data       = pix_data_q;
  assign pix_data_valid = valid2_q;
  assign busy           = (state_q == ST_REVEAL);
  assign done           = done_q;

endmodule

// File: tb/tb_text_reveal_ctrl.sv
// Bench for text_reveal_ctrl: directed scenarios plus random traffic, all
// outputs compared every cycle against a behavioural model of the text line.
module tb_text_reveal_ctrl;

  localparam int TL = 4;
  localparam int RF = 2;
  localparam logic [15:0] FG = 16'hFFFF;
  localparam logic [15:0] BG = 16'h0000;

  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [4:0]  wr_char = '0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b1;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic [4:0]  letter_i;
  logic [3:0]  letter_x;
  logic [3:0]  letter_y;
  logic        letter_o;
  logic [15:0] pix_data;
  logic        pix_data_valid;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  bit chk_en = 0;

  // Behavioural model: mode 0 idle, 1 revealing, 2 showing
  int m_mode, m_rev, m_frm, m_buf[TL];
  bit m_done, m_in_box, m_valid1, m_pv;
  int m_slot, m_lx, m_ly;
  logic [15:0] m_pix;

  text_reveal_ctrl #(
    .TEXT_LEN(TL), .ORIGIN_X(0), .ORIGIN_Y(0), .REVEAL_FRAMES(RF),
    .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_char(wr_char), .start(start), .clear(clear), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .letter_i(letter_i),
    .letter_x(letter_x), .letter_y(letter_y), .letter_o(letter_o),
    .pix_data(pix_data), .pix_data_valid(pix_data_valid), .busy(busy), .done(done)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic bit romBit(input int l, input int x, input int y);
    return (l < 26) && (((l + x + 2 * y) % 3) == 0);
  endfunction

  assign letter_o = romBit(int'(letter_i), int'(letter_x), int'(letter_y));

  function automatic int expLetter();
    bit vis;
    if (!m_in_box) return 26;
    vis = (m_mode == 2) || (m_mode == 1 && m_slot < m_rev);
    if (vis && m_buf[m_slot] <= 26) return m_buf[m_slot];
    return 26;
  endfunction

  always @(posedge vga_clk) begin : model
    int dx, dy, el;
    if (sys_rst) begin
      m_mode = 0; m_rev = 0; m_frm = 0; m_done = 0;
      for (int i = 0; i < TL; i++) m_buf[i] = 26;
      m_in_box = 0; m_valid1 = 0; m_pv = 0; m_pix = BG;
      m_slot = 0; m_lx = 0; m_ly = 0;
      chk_en = 1;
    end else begin
      el = expLetter();
      m_pix = (m_in_box && romBit(el, m_lx, m_ly)) ? FG : BG;
      m_pv = m_valid1;
      dx = int'(pix_x);
      dy = int'(pix_y);
      m_valid1 = pix_valid;
      m_in_box = pix_valid && dx < 16 * TL && dy < 16;
      m_slot = m_in_box ? dx / 16 : 0;
      m_lx = m_in_box ? dx % 16 : 0;
      m_ly = m_in_box ? dy % 16 : 0;
      m_done = 0;
      if (clear) begin
        m_mode = 0; m_rev = 0; m_frm = 0;
      end else if (start) begin
        m_mode = 1; m_rev = 0; m_frm = 0;
      end else if (m_mode == 1 && frame_start) begin
        m_frm++;
        if (m_frm == RF) begin
          m_frm = 0;
          m_rev++;
          if (m_rev == TL) begin
            m_mode = 2;
            m_done = 1;
          end
        end
      end
      if (wr_en) m_buf[wr_addr] = int'(wr_char);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge vga_clk) begin
    if (chk_en) begin
      checkOutput("letter_i", 32'(letter_i), 32'(expLetter()));
      checkOutput("letter_x", 32'(letter_x), 32'(m_lx));
      checkOutput("letter_y", 32'(letter_y), 32'(m_ly));
      checkOutput("pix_data", 32'(pix_data), 32'(m_pix));
      checkOutput("pix_valid", 32'(pix_data_valid), 32'(m_pv));
      checkOutput("busy", 32'(busy), 32'(m_mode == 1));
      checkOutput("done", 32'(done), 32'(m_done));
      if (done === 1'b1) done_seen++;
    end
  end

  task automatic applyStimulus(input logic rst, input logic we, input logic [1:0] wa,
                               input logic [4:0] wc, input logic st, input logic cl,
                               input logic fs, input logic pv, input logic [9:0] px,
                               input logic [9:0] py);
    @(negedge vga_clk);
    sys_rst = rst; wr_en = we; wr_addr = wa; wr_char = wc;
    start = st; clear = cl; frame_start = fs;
    pix_valid = pv; pix_x = px; pix_y = py;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pixelAt(input int x, input int y);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 10'(x), 10'(y));
  endtask

  task automatic frameTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      idle(2);
    end
  endtask

  task automatic probeLetter(input string name, input int x, input int y, input logic pv,
                             input int exp);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, pv, 10'(x), 10'(y));
    @(negedge vga_clk);
    checkOutput(name, 32'(letter_i), 32'(exp));
  endtask

  initial begin : stim
    int d0;
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (4) pixelAt(0, 0);
    checkOutput("rst_letter", 32'(letter_i), 32'd26);
    checkOutput("rst_pix", 32'(pix_data), 32'h0000);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);

    for (int i = 0; i < TL; i++) applyStimulus(0, 1, 2'(i), 5'(i), 0, 0, 0, 0, 0, 0);
    d0 = done_seen;
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    frameTicks(2);
    probeLetter("rev1_x0", 0, 3, 1, 0);
    probeLetter("rev1_x15", 15, 3, 1, 0);
    probeLetter("rev1_x16", 16, 3, 1, 26);
    probeLetter("rev1_x63", 63, 3, 1, 26);
    for (int x = 0; x < 64; x++) pixelAt(x, 7);
    frameTicks(6);
    idle(3);
    checkOutput("done_once", 32'(done_seen - d0), 32'd1);
    checkOutput("show_busy", 32'(busy), 32'd0);

    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 64; x++) pixelAt(x, y);
    probeLetter("show_x5", 5, 2, 1, 0);
    probeLetter("show_x50", 50, 2, 1, 3);
    probeLetter("edge_x64", 64, 0, 1, 26);
    probeLetter("edge_y16", 10, 16, 1, 26);
    probeLetter("pv_low", 10, 5, 0, 26);
    applyStimulus(0, 1, 2'd1, 5'd30, 0, 0, 0, 0, 0, 0);
    probeLetter("code30", 20, 2, 1, 26);

    pixelAt(32, 1);
    applyStimulus(0, 1, 2'd2, 5'd7, 0, 0, 0, 1, 10'd33, 10'd1);
    checkOutput("wr_old", 32'(letter_i), 32'd2);
    pixelAt(34, 1);
    checkOutput("wr_new", 32'(letter_i), 32'd7);

    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    frameTicks(1);
    d0 = done_seen;
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(1);
    checkOutput("clr_busy", 32'(busy), 32'd0);
    frameTicks(10);
    checkOutput("clr_nodone", 32'(done_seen - d0), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      logic [9:0] rx, ry;
      rx = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 79));
      ry = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 19));
      applyStimulus(($urandom_range(0, 999) < 3), ($urandom_range(0, 9) == 0),
                    2'($urandom), 5'($urandom), ($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 15),
                    ($urandom_range(0, 9) < 8), rx, ry);
    end

    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TL; i++) applyStimulus(0, 1, 2'(i), 5'(i + 4), 0, 0, 0, 0, 0, 0);
    frameTicks(3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 10'd5, 10'd0);
    idle(1);
    checkOutput("rst2_busy", 32'(busy), 32'd0);
    checkOutput("rst2_done", 32'(done), 32'd0);
    checkOutput("rst2_letter", 32'(letter_i), 32'd26);
    checkOutput("rst2_lx", 32'(letter_x), 32'd0);
    checkOutput("rst2_pix", 32'(pix_data), 32'h0000);
    checkOutput("rst2_pv", 32'(pix_data_valid), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    frameTicks(RF * TL);
    idle(2);
    checkOutput("rst2_show", 32'(busy), 32'd0);
    for (int s = 0; s < TL; s++) probeLetter("rst2_blank", s * 16 + 3, 4, 1, 26);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
